// File: rtl/mul_row_collect.sv
// Receive end of the multiplier datapath: packs fixed-latency products into rows
// and offers them through a two-bank ping-pong buffer on a valid/ready handshake.
module mul_row_collect #(
  parameter int DATA_W  = 32,
  parameter int LAT     = 7,
  parameter int ROW_LEN = 8,
  parameter int IDX_W   = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         in_data,
  output logic [DATA_W*ROW_LEN-1:0] out_row,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      overflow
);

  logic [LAT-1:0]    vpipe;
  logic [IDX_W-1:0]  idx;
  logic [1:0]        bank_full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic              rd_nxt;
  logic [DATA_W-1:0] mem [2][ROW_LEN];

  logic sample;
  logic xfer;
  logic wr_free;
  logic do_write;
  logic do_drop;
  logic row_done;

  // A transfer freeing the bank being filled lets a same-cycle sample land in it.
  always_comb begin
    sample   = vpipe[LAT-1];
    xfer     = out_valid && out_ready;
    wr_free  = !bank_full[wr_bank] || (xfer && (rd_bank == wr_bank));
    do_write = sample && !flush && wr_free;
    do_drop  = sample && !flush && !wr_free;
    row_done = do_write && (idx == IDX_W'(ROW_LEN - 1));
    full_nxt = bank_full;
    if (xfer)
      full_nxt[rd_bank] = 1'b0;
    if (row_done)
      full_nxt[wr_bank] = 1'b1;
    rd_nxt = rd_bank ^ xfer;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe     <= '0;
      idx       <= '0;
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < ROW_LEN; k++)
          mem[b][k] <= '0;
    end else begin
      vpipe[0] <= enable;
      for (int k = 1; k < LAT; k++)
        vpipe[k] <= vpipe[k-1];
      bank_full <= full_nxt;
      rd_bank   <= rd_nxt;
      out_valid <= full_nxt[rd_nxt];
      if (do_drop)
        overflow <= 1'b1;
      if (flush) begin
        idx <= '0;
      end else if (do_write) begin
        mem[wr_bank][idx] <= in_data;
        if (row_done) begin
          idx     <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_row = '0;
    for (int k = 0; k < ROW_LEN; k++)
      out_row[DATA_W*k +: DATA_W] = mem[rd_bank][k];
  end

endmodule

// File: tb/tb_mul_row_collect.sv
// Randomised and directed bench for mul_row_collect, checked every cycle against a
// queue-based model of captured products and completed rows.
module tb_mul_row_collect;

  localparam int DATA_W  = 32;
  localparam int LAT     = 7;
  localparam int ROW_LEN = 8;
  localparam int IDX_W   = 3;
  localparam int RW      = DATA_W * ROW_LEN;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              flush;
  logic              out_ready;
  logic [DATA_W-1:0] in_data;
  logic [RW-1:0]     out_row;
  logic              out_valid;
  logic              overflow;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  int                cap_q[$];
  logic [DATA_W-1:0] part[$];
  logic [RW-1:0]     mrows[$];
  logic              m_ovf;

  mul_row_collect #(
    .DATA_W(DATA_W), .LAT(LAT), .ROW_LEN(ROW_LEN), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .in_data(in_data),
    .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic expectBit(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cyc %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic expectRow(input string name, input logic [RW-1:0] act,
                           input logic [RW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic modelReset();
    cap_q.delete();
    part.delete();
    mrows.delete();
    m_ovf = 1'b0;
  endtask

  // Each enable schedules one capture LAT edges later; a product is kept while
  // fewer than two completed rows are held after this edge's transfer.
  task automatic modelEdge();
    logic          s;
    logic          xfer;
    int            held;
    logic [RW-1:0] r;
    s = (cap_q.size() > 0) && (cap_q[0] == cyc);
    if (s) void'(cap_q.pop_front());
    if (enable) cap_q.push_back(cyc + LAT);
    xfer = (mrows.size() > 0) && out_ready;
    held = mrows.size() - (xfer ? 1 : 0);
    if (s && !flush) begin
      if (held < 2) begin
        part.push_back(in_data);
        if (part.size() == ROW_LEN) begin
          r = '0;
          for (int k = 0; k < ROW_LEN; k++) r[DATA_W*k +: DATA_W] = part[k];
          mrows.push_back(r);
          part.delete();
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (flush) part.delete();
    if (xfer) void'(mrows.pop_front());
  endtask

  task automatic checkOutput();
    expectBit("out_valid", out_valid, mrows.size() > 0);
    expectBit("overflow", overflow, m_ovf);
    if (mrows.size() > 0) expectRow("out_row", out_row, mrows[0]);
  endtask

  task automatic applyStimulus(input logic en, input logic fl, input logic rdy,
                               input logic [DATA_W-1:0] d);
    enable    = en;
    flush     = fl;
    out_ready = rdy;
    in_data   = d;
    @(posedge clk);
    cyc++;
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    enable    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    modelReset();
    expectBit("rst_out_valid", out_valid, 1'b0);
    expectBit("rst_overflow", overflow, 1'b0);
    expectRow("rst_out_row", out_row, '0);
    @(posedge clk);
    cyc++;
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [RW-1:0] lit;

    rst = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
    modelReset();
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #2 rst = 1'b1;
    expectBit("init_out_valid", out_valid, 1'b0);

    // Single row, consumer always ready: valid for exactly one cycle at edge 15.
    for (int n = 1; n <= 16; n++) begin
      applyStimulus(n <= 8, 1'b0, 1'b1,
                    (n >= 8 && n <= 15) ? DATA_W'(n - 7) : DATA_W'(32'hDEAD0000 + n));
      if (n == 14) expectBit("t1_pre", out_valid, 1'b0);
      if (n == 15) begin
        for (int k = 0; k < ROW_LEN; k++) lit[DATA_W*k +: DATA_W] = DATA_W'(k + 1);
        expectBit("t1_valid", out_valid, 1'b1);
        expectRow("t1_row", out_row, lit);
        if (mrows.size() > 0) expectRow("t1_model", mrows[0], lit);
        else expectBit("t1_model_rows", 1'b0, 1'b1);
      end
      if (n == 16) expectBit("t1_done", out_valid, 1'b0);
    end
    expectBit("t1_ovf", overflow, 1'b0);

    // Flush through the tail of a short burst; only the later burst forms a row.
    for (int n = 1; n <= 28; n++) begin
      applyStimulus((n <= 5) || (n >= 13 && n <= 20), n >= 10 && n <= 12, 1'b1,
                    DATA_W'(100 + n));
      if (n == 19) expectBit("t3_no_partial", out_valid, 1'b0);
      if (n == 27) begin
        for (int k = 0; k < ROW_LEN; k++) lit[DATA_W*k +: DATA_W] = DATA_W'(120 + k);
        expectBit("t3_valid", out_valid, 1'b1);
        expectRow("t3_row", out_row, lit);
      end
    end

    // Stalled consumer: two rows held, the third row's products dropped.
    for (int n = 1; n <= 34; n++) applyStimulus(n <= 24, 1'b0, 1'b0, $urandom);
    expectBit("t2_ovf", overflow, 1'b1);
    expectBit("t2_held", out_valid, 1'b1);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
      if (n == 1) expectBit("t2_second", out_valid, 1'b1);
    end
    expectBit("t2_empty", out_valid, 1'b0);
    doReset();

    // Both banks full; a transfer on the capture edge lets that product in.
    for (int n = 1; n <= 30; n++) applyStimulus(n <= 17, 1'b0, n == 24, DATA_W'(200 + n));
    expectBit("t4_ovf", overflow, 1'b0);
    for (int n = 1; n <= 4; n++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);

    // Reset while products are in flight, then a clean burst.
    for (int n = 1; n <= 5; n++) applyStimulus(n <= 4, 1'b0, 1'b1, $urandom);
    doReset();
    for (int n = 1; n <= 12; n++) applyStimulus(1'b0, 1'b0, 1'b1, $urandom);
    expectBit("t5_quiet", out_valid, 1'b0);
    for (int n = 1; n <= 18; n++) applyStimulus(n <= 8, 1'b0, 1'b1, $urandom);

    // Alternating enable: gap values are never stored.
    for (int n = 1; n <= 26; n++) applyStimulus((n <= 16) && n[0], 1'b0, 1'b1, $urandom);

    for (int n = 0; n < 600; n++)
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) == 1, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
